// File: rtl/trace_readout.sv
// Trace buffer readout: walks sample numbers Begin..End, fetches each packet and streams it MSB-first as bytes.
// Optional 12-byte {Begin, End, Trig} header enabled by defining TRACE_READOUT_HEADER_EN.
module trace_readout #(
    parameter int SAMPLE_PACKET_WIDTH = 32,
    parameter int ADDR_WIDTH          = 12
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [31:0]                    sampleNumber_Begin,
    input  logic [31:0]                    sampleNumber_End,
    input  logic [31:0]                    sampleNumber_Trig,
    output logic                           mem_rd_en,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic [SAMPLE_PACKET_WIDTH-1:0] mem_rd_data,
    output logic [7:0]                     tx_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic                           busy,
    output logic                           done,
    output logic [31:0]                    bytes_sent
);
    localparam int PKT_BYTES = SAMPLE_PACKET_WIDTH / 8;
    localparam int BCW       = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

    typedef enum logic [2:0] {IDLE, HEADER, FETCH, WAIT, SEND, DONE} state_t;
    state_t state, state_next;

    logic [31:0]                    cur;
    logic [31:0]                    remaining;
    logic [SAMPLE_PACKET_WIDTH-1:0] pkt;
    logic [BCW-1:0]                 byte_idx;
    logic                           accept;
    logic                           last_byte;

`ifdef TRACE_READOUT_HEADER_EN
    logic [95:0] hdr;
    logic [3:0]  hdr_idx;
`else
    logic unused_trig;
    assign unused_trig = ^sampleNumber_Trig;
`endif

    assign accept    = tx_valid & tx_ready;
    assign last_byte = (byte_idx == BCW'(PKT_BYTES - 1));

    always_comb begin
        state_next = state;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE: begin
`ifdef TRACE_READOUT_HEADER_EN
                if (start) state_next = HEADER;
`else
                if (start) state_next = FETCH;
`endif
            end
`ifdef TRACE_READOUT_HEADER_EN
            HEADER: begin
                tx_valid = 1'b1;
                tx_data  = hdr[95:88];
                if (accept && hdr_idx == 4'd11) state_next = FETCH;
            end
`endif
            FETCH: begin
                mem_rd_en  = 1'b1;
                mem_addr   = cur[ADDR_WIDTH-1:0];
                state_next = WAIT;
            end
            WAIT: state_next = SEND;
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = pkt[SAMPLE_PACKET_WIDTH-1 -: 8];
                if (accept && last_byte) state_next = (remaining == 32'd0) ? DONE : FETCH;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Abort overrides everything, including a handshake completing this cycle.
        if (abort) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cur        <= '0;
            remaining  <= '0;
            pkt        <= '0;
            byte_idx   <= '0;
            bytes_sent <= '0;
`ifdef TRACE_READOUT_HEADER_EN
            hdr        <= '0;
            hdr_idx    <= '0;
`endif
        end else begin
            state <= state_next;
            if (accept) bytes_sent <= bytes_sent + 32'd1;
            case (state)
                IDLE: if (start && !abort) begin
                    cur        <= sampleNumber_Begin;
                    remaining  <= sampleNumber_End - sampleNumber_Begin;
                    bytes_sent <= '0;
`ifdef TRACE_READOUT_HEADER_EN
                    hdr        <= {sampleNumber_Begin, sampleNumber_End, sampleNumber_Trig};
                    hdr_idx    <= '0;
`endif
                end
`ifdef TRACE_READOUT_HEADER_EN
                HEADER: if (accept) begin
                    hdr     <= hdr << 8;
                    hdr_idx <= hdr_idx + 4'd1;
                end
`endif
                WAIT: begin
                    pkt      <= mem_rd_data;
                    byte_idx <= '0;
                end
                SEND: if (accept) begin
                    pkt      <= pkt << 8;
                    byte_idx <= byte_idx + BCW'(1);
                    if (last_byte && remaining != 32'd0) begin
                        cur       <= cur + 32'd1;
                        remaining <= remaining - 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_trace_readout.sv
// Randomized bench for trace_readout: expected byte stream and address sequence built from sample-number arithmetic.
module tb_trace_readout;
    localparam int AW = 4;
    localparam int W  = 32;

    logic          clk = 1'b0;
    logic          reset, start, abort, tx_ready;
    logic [31:0]   sampleNumber_Begin, sampleNumber_End, sampleNumber_Trig;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_rd_data;
    logic [7:0]    tx_data;
    logic          tx_valid, busy, done;
    logic [31:0]   bytes_sent;

    logic [W-1:0]  mem [16];
    int            n_checks = 0;
    int            n_pass   = 0;

    trace_readout #(.SAMPLE_PACKET_WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .sampleNumber_Begin(sampleNumber_Begin), .sampleNumber_End(sampleNumber_End),
        .sampleNumber_Trig(sampleNumber_Trig), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done), .bytes_sent(bytes_sent)
    );

    always #5 clk = ~clk;

    // one-cycle read latency memory
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic run(input logic [31:0] b, input logic [31:0] e, input logic [31:0] t,
                       input int rnd_ready, input int abort_at);
        logic [7:0]    exp_q[$];
        logic [AW-1:0] addr_q[$];
        logic [31:0]   n, w;
        logic [7:0]    held;
        int            acc, dones, last_rd, first_rd;
        bit            stalled, finished, abort_pend, aborted;
        n = e - b;
`ifdef TRACE_READOUT_HEADER_EN
        for (int i = 3; i >= 0; i--) exp_q.push_back(b[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) exp_q.push_back(e[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) exp_q.push_back(t[i*8 +: 8]);
`endif
        for (int k = 0; k <= int'(n); k++) begin
            addr_q.push_back(AW'(b + 32'(k)));
            w = mem[AW'(b + 32'(k))];
            for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
        end
        acc = 0; dones = 0; last_rd = -10; first_rd = -1;
        stalled = 0; finished = 0; abort_pend = 0; aborted = 0; held = '0;

        @(posedge clk); #1;
        start = 1'b1; sampleNumber_Begin = b; sampleNumber_End = e; sampleNumber_Trig = t;
        tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);

        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (!busy) begin finished = 1; break; end
            if (mem_rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                if (addr_q.size() == 0) chk("extra_rd", 1, 0);
                else chk("mem_addr", mem_addr, addr_q.pop_front());
            end
            if (cyc == last_rd + 1) chk("wait_no_valid", tx_valid, 0);
            if (cyc == last_rd + 2) chk("rd_to_valid", tx_valid, 1);
            if (stalled) begin
                chk("stall_valid", tx_valid, 1);
                chk("stall_data", tx_data, held);
            end
            if (done) dones++;
            stalled = 0;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) chk("extra_byte", 1, 0);
                else chk("tx_byte", tx_data, exp_q.pop_front());
                acc++;
                if (abort_at > 0 && acc == abort_at) abort_pend = 1;
            end else if (tx_valid) begin
                stalled = 1; held = tx_data;
            end
            @(posedge clk); #1;
            if (cyc == 4) begin start = 1'b1; sampleNumber_Begin = ~b; end
            if (cyc == 5) begin start = 1'b0; sampleNumber_Begin = b; end
            tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (abort_pend) begin
                abort = 1'b1; tx_ready = 1'b0;
                @(posedge clk); #1;
                abort = 1'b0; start = 1'b0;
                chk("abort_valid", tx_valid, 0);
                chk("abort_rd", mem_rd_en, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_bytes", bytes_sent, 32'(abort_at));
                aborted = 1;
                break;
            end
        end
        start = 1'b0; sampleNumber_Begin = b;

        if (aborted) begin
            chk("abort_no_done", dones, 0);
        end else begin
            chk("timeout", finished, 1);
            chk("done_count", dones, 1);
            chk("bytes_left", exp_q.size(), 0);
            chk("addr_left", addr_q.size(), 0);
`ifndef TRACE_READOUT_HEADER_EN
            chk("start_to_rd", first_rd, 0);
`endif
            chk("bytes_sent", bytes_sent, 32'(acc));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("idle_bytes_hold", bytes_sent, aborted ? 32'(abort_at) : 32'(acc));
    endtask

    initial begin
        int hdr_b;
        reset = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
        sampleNumber_Begin = '0; sampleNumber_End = '0; sampleNumber_Trig = '0;
`ifdef TRACE_READOUT_HEADER_EN
        hdr_b = 12;
`else
        hdr_b = 0;
`endif
        for (int i = 0; i < 16; i++) mem[i] = 32'hA0B0C0D0 + 32'(i);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", tx_valid, 0);
        chk("rst_rd", mem_rd_en, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_bytes", bytes_sent, 0);
        reset = 1'b0;

        run(32'd0, 32'd3, 32'd0, 0, 0);
        chk("basic_total", bytes_sent, 32'(16 + hdr_b));
        run(32'd0, 32'd3, 32'd2, 1, 0);
        run(32'd14, 32'd17, 32'd15, 1, 0);
        run(32'd5, 32'd5, 32'd5, 0, 0);
        chk("single_total", bytes_sent, 32'(4 + hdr_b));
        run(32'd0, 32'd3, 32'd1, 0, 6);
        run(32'hFFFF_FFFE, 32'd1, 32'd0, 1, 0);
        run(32'h10, 32'h11, 32'h10, 0, 0);
        chk("hdr_case_total", bytes_sent, 32'(8 + hdr_b));

        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        for (int r = 0; r < 4; r++) begin
            logic [31:0] b;
            b = $urandom;
            run(b, b + 32'($urandom_range(0, 4)), $urandom, 1, 0);
        end

        // reset in the middle of a readout
        @(posedge clk); #1;
        start = 1'b1; sampleNumber_Begin = 32'd0; sampleNumber_End = 32'd3; tx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", tx_valid, 0);
        chk("mid_rst_bytes", bytes_sent, 0);
        chk("mid_rst_done", done, 0);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_done", done, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
